// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the control FSM that consumes it.
// Holds the fetch state encoding, the default address/data widths and the
// reset PC, plus a helper that classifies states as busy.
package instruction_fetch_unit_pkg;

    localparam int              IFU_ADDR_W   = 16;
    localparam int              IFU_DATA_W   = 16;
    localparam logic [15:0]     IFU_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    function automatic logic state_is_busy(input fetch_state_t s);
        return (s != IDLE);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, rst  : core clock, synchronous active-high reset (pc <= RESET_PC)
//   load      : redirect; takes priority over inc
//   load_val  : redirect target
//   inc       : advance to the next word, wrapping modulo 2^ADDR_W
//   pc        : current program counter
module instruction_fetch_unit_program_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = IFU_RESET_PC[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            // Natural overflow of the ADDR_W-bit sum gives the required wrap.
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage for the 16-bit RISC core.
// Owns the PC, issues word reads to main memory with a ready handshake,
// captures the returned word and offers it (with its address) to the
// instruction register through a valid/ready handshake. Redirects from the
// control FSM flush the stage; a read that never completes raises a sticky
// fetch_err.
// Ports:
//   clk, rst                 : core clock, synchronous active-high reset
//   enable                   : permits starting new reads
//   mem_read/mem_addr        : read request and its (stable) address
//   mem_rdata/mem_ready      : read data and completion strobe
//   instr/instr_pc/instr_valid, instr_ready : fetched word to consumer
//   pc_load/pc_load_val      : redirect request and target
//   pc                       : next fetch address
//   busy                     : stage in REQ, HOLD or FLUSH
//   fetch_err                : sticky memory timeout flag
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter int                DATA_W   = IFU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = IFU_RESET_PC[ADDR_W-1:0],
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_t      state, state_nxt;
    logic [CNT_W-1:0]  tmo_cnt;

    // Registered output stage: captured word, its address and its valid.
    logic [DATA_W-1:0] instr_p1;
    logic [ADDR_W-1:0] instr_pc_p1;
    logic              vld_p1;
    logic              err_p1;

    logic pc_load_en, pc_inc_en, capture;
    logic vld_clr, err_set, err_clr, cnt_clr, cnt_inc;

    instruction_fetch_unit_program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load_en),
        .load_val (pc_load_val),
        .inc      (pc_inc_en),
        .pc       (pc)
    );

    always_comb begin
        state_nxt  = state;
        pc_load_en = 1'b0;
        pc_inc_en  = 1'b0;
        capture    = 1'b0;
        vld_clr    = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        if (pc_load) begin
            // Redirect wins everywhere: any returning data or pending
            // consumer handshake in this cycle is discarded.
            state_nxt  = FLUSH;
            pc_load_en = 1'b1;
            vld_clr    = 1'b1;
            err_clr    = 1'b1;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !err_p1) begin
                        state_nxt = REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        capture   = 1'b1;
                        pc_inc_en = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = HOLD;
                    end else if (tmo_cnt == CNT_LAST) begin
                        err_set   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_inc   = 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        vld_clr   = 1'b1;
                        state_nxt = enable ? REQ : IDLE;
                    end
                end
                FLUSH: begin
                    state_nxt = enable ? REQ : IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Stage p0 -> p1: state, memory request and captured word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            mem_read    <= 1'b0;
            mem_addr    <= '0;
            instr_p1    <= '0;
            instr_pc_p1 <= '0;
            vld_p1      <= 1'b0;
            err_p1      <= 1'b0;
        end else begin
            state    <= state_nxt;
            // pc never changes on a transition into REQ (increments leave
            // for HOLD, loads leave for FLUSH), so the current pc is the
            // address for the whole request.
            mem_read <= (state_nxt == REQ);
            if (state_nxt == REQ) begin
                mem_addr <= pc;
            end

            if (cnt_clr) begin
                tmo_cnt <= '0;
            end else if (cnt_inc) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if (capture) begin
                instr_p1    <= mem_rdata;
                instr_pc_p1 <= pc;
            end

            if (capture) begin
                vld_p1 <= 1'b1;
            end else if (vld_clr) begin
                vld_p1 <= 1'b0;
            end

            if (err_clr) begin
                err_p1 <= 1'b0;
            end else if (err_set) begin
                err_p1 <= 1'b1;
            end
        end
    end

    assign instr       = instr_p1;
    assign instr_pc    = instr_pc_p1;
    assign instr_valid = vld_p1;
    assign fetch_err   = err_p1;
    assign busy        = state_is_busy(state);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Memory returns addr ^ 16'h5A00;
// expected words are queued by the stimulus and checked by a monitor each time
// instr_valid rises, and held stable while valid stays high.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] pc;
    logic        busy;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] addr;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr ^ 16'h5A00;

    instruction_fetch_unit #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .RESET_PC (16'h0000),
        .TIMEOUT  (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .pc          (pc),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        enable      = 1'b0;
        mem_ready   = 1'b0;
        instr_ready = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = 16'h0000;
        step();
        step();
        chk("rst_pc",        32'(pc),          32'h0000);
        chk("rst_mem_read",  32'(mem_read),    32'h0);
        chk("rst_mem_addr",  32'(mem_addr),    32'h0000);
        chk("rst_instr",     32'(instr),       32'h0000);
        chk("rst_instr_pc",  32'(instr_pc),    32'h0000);
        chk("rst_valid",     32'(instr_valid), 32'h0);
        chk("rst_fetch_err", 32'(fetch_err),   32'h0);
        chk("rst_busy",      32'(busy),        32'h0);
        rst = 1'b0;
    endtask

    // Monitor: a rising instr_valid presents a new word; while valid stays
    // high the word and its address must not move.
    initial begin
        logic prev_vld;
        exp_t cur;
        prev_vld = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_vld = 1'b0;
            end else begin
                if (instr_valid && !prev_vld) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_instr actual=%0h@%0h required=none", instr, instr_pc);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("instr",    32'(instr),    32'(cur.word));
                        chk("instr_pc", 32'(instr_pc), 32'(cur.addr));
                    end
                end else if (instr_valid && prev_vld) begin
                    chk("instr_stable",    32'(instr),    32'(cur.word));
                    chk("instr_pc_stable", 32'(instr_pc), 32'(cur.addr));
                end
                prev_vld = instr_valid;
            end
        end
    end

    initial begin
        do_reset();

        // Streaming fetch with memory and consumer always ready.
        exp_q.push_back('{word: 16'h5A00, addr: 16'h0000});
        exp_q.push_back('{word: 16'h5A01, addr: 16'h0001});
        exp_q.push_back('{word: 16'h5A02, addr: 16'h0002});
        enable = 1'b1; mem_ready = 1'b1; instr_ready = 1'b1;
        step();
        chk("s1_mem_read0", 32'(mem_read), 32'h1);
        chk("s1_mem_addr0", 32'(mem_addr), 32'h0000);
        step();
        chk("s1_pc1",       32'(pc),       32'h0001);
        chk("s1_hold_rd",   32'(mem_read), 32'h0);
        step();
        chk("s1_mem_addr1", 32'(mem_addr), 32'h0001);
        step();
        chk("s1_pc2",       32'(pc),       32'h0002);
        step();
        step();
        chk("s1_pc3",       32'(pc),       32'h0003);
        enable = 1'b0;
        step();
        chk("s1_idle_busy", 32'(busy),     32'h0);

        // Memory ready after three wait cycles; enable dropped mid-read.
        exp_q.push_back('{word: 16'h5A03, addr: 16'h0003});
        mem_ready = 1'b0; enable = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("s2_mem_read", 32'(mem_read),    32'h1);
            chk("s2_mem_addr", 32'(mem_addr),    32'h0003);
            chk("s2_no_valid", 32'(instr_valid), 32'h0);
            enable = 1'b0;
            if (i == 3) mem_ready = 1'b1;
            step();
        end
        mem_ready = 1'b0;
        chk("s2_valid",     32'(instr_valid), 32'h1);
        chk("s2_rd_off",    32'(mem_read),    32'h0);
        step();
        chk("s2_valid_clr", 32'(instr_valid), 32'h0);
        chk("s2_idle",      32'(busy),        32'h0);

        // Consumer stalls five cycles in HOLD.
        do_reset();
        exp_q.push_back('{word: 16'h5A00, addr: 16'h0000});
        enable = 1'b1; mem_ready = 1'b1; instr_ready = 1'b0;
        step();
        enable = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("s3_valid",    32'(instr_valid), 32'h1);
            chk("s3_mem_read", 32'(mem_read),    32'h0);
            chk("s3_pc",       32'(pc),          32'h0001);
            step();
        end
        instr_ready = 1'b1;
        chk("s3_valid6",   32'(instr_valid), 32'h1);
        step();
        chk("s3_accepted", 32'(instr_valid), 32'h0);
        chk("s3_idle",     32'(busy),        32'h0);

        // Redirect coinciding with mem_ready: data dropped, one FLUSH cycle.
        do_reset();
        exp_q.push_back('{word: 16'h5A40, addr: 16'h0040});
        enable = 1'b1; mem_ready = 1'b0; instr_ready = 1'b1;
        step();
        mem_ready = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0040;
        step();
        pc_load = 1'b0;
        chk("s4_flush_vld",  32'(instr_valid), 32'h0);
        chk("s4_flush_rd",   32'(mem_read),    32'h0);
        chk("s4_flush_pc",   32'(pc),          32'h0040);
        chk("s4_flush_busy", 32'(busy),        32'h1);
        step();
        chk("s4_req_rd",     32'(mem_read),    32'h1);
        chk("s4_req_addr",   32'(mem_addr),    32'h0040);
        enable = 1'b0;
        step();
        chk("s4_pc_next",    32'(pc),          32'h0041);
        step();

        // Redirect to the top of memory; pc wraps after the fetch.
        exp_q.push_back('{word: 16'hA5FF, addr: 16'hFFFF});
        pc_load = 1'b1; pc_load_val = 16'hFFFF; enable = 1'b1;
        step();
        pc_load = 1'b0;
        chk("s5_pc_load", 32'(pc), 32'hFFFF);
        step();
        chk("s5_req_addr", 32'(mem_addr), 32'hFFFF);
        enable = 1'b0;
        step();
        chk("s5_pc_wrap", 32'(pc), 32'h0000);
        step();

        // Memory never answers: timeout after 15 REQ cycles, then recovery.
        do_reset();
        enable = 1'b1; mem_ready = 1'b0; instr_ready = 1'b1;
        step();
        for (int c = 0; c < 15; c++) begin
            chk("s6_req_rd",  32'(mem_read),  32'h1);
            chk("s6_no_err",  32'(fetch_err), 32'h0);
            step();
        end
        chk("s6_err",      32'(fetch_err), 32'h1);
        chk("s6_rd_off",   32'(mem_read),  32'h0);
        chk("s6_idle",     32'(busy),      32'h0);
        chk("s6_pc_keep",  32'(pc),        32'h0000);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("s6_blocked", 32'(mem_read), 32'h0);
            chk("s6_sticky",  32'(fetch_err), 32'h1);
        end
        exp_q.push_back('{word: 16'h5A10, addr: 16'h0010});
        pc_load = 1'b1; pc_load_val = 16'h0010;
        step();
        pc_load = 1'b0; mem_ready = 1'b1;
        chk("s6_err_clr", 32'(fetch_err), 32'h0);
        step();
        chk("s6_resume_addr", 32'(mem_addr), 32'h0010);
        chk("s6_resume_rd",   32'(mem_read), 32'h1);
        enable = 1'b0;
        step();
        step();
        step();

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
